ising_job_sequencer: RTL and testbench
======================================

// Module: ising_job_sequencer
// PURPOSE
// Hardware initiator for the ising_axi register interface; it replaces the host/testbench that drives it.
// Per job it writes CTR_CUTOFF, CTR_MAX and a stream of weights, then writes START.
// It then waits a programmed anneal time and reads back all N phase bits into a parallel result vector.
// It sits between a job source (CPU shim or weight ROM streamer) and one ising_axi instance.
// PARAMETERS
// N           8   spins in the array; also the number of phase words read back
// WIDX_W      32  width of the weight-index field added to `WEIGHT_ADDR_BASE
// ANNEAL_W    32  width of the anneal wait counter
// RD_LATENCY  1   cycles from araddr_q change to rdata valid in ising_axi
// PORTS
// clk           in   1         single clock, shared with ising_axi
// axi_rst       in   1         asynchronous, active-high reset
// job_start     in   1         pulse; accepted only in IDLE
// job_abort     in   1         level; forces return to IDLE from any state
// cfg_cutoff    in   32        value written to `CTR_CUTOFF_ADDR
// cfg_ctr_max   in   32        value written to `CTR_MAX_ADDR
// cfg_anneal    in   ANNEAL_W  cycles to wait after START before the readback
// w_valid       in   1         weight beat valid
// w_ready       out  1         weight beat accept; high only in LOAD_W
// w_idx         in   WIDX_W    weight offset added to `WEIGHT_ADDR_BASE
// w_data        in   32        weight value
// w_last        in   1         final weight beat of the job
// wr_en         out  1         write strobe, drives the ising_axi wready
// wr_addr       out  32        write address to ising_axi
// wdata         out  32        write data to ising_axi
// arvalid_q     out  1         read request to ising_axi
// araddr_q      out  32        read address to ising_axi
// rdata         in   32        read data from ising_axi; bit 0 = phase
// busy          out  1         high in every state except IDLE
// done          out  1         one-cycle pulse when phase_vec is updated
// phase_vec     out  N         bit i = phase of spin i, held until the next done
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; phase_vec 0. Async assert, sync release.
// - All outputs are registered. A write is a single cycle with wr_en=1; wr_addr and wdata are valid in that cycle.
// - FSM states: IDLE, W_CUT, W_MAX, LOAD_W, W_START, ANNEAL, RD_REQ, RD_WAIT, FINISH.
// - IDLE -> W_CUT on job_start. Configuration inputs are sampled in that cycle; later changes are ignored until the next job.
// - W_CUT: one write of cfg_cutoff to `CTR_CUTOFF_ADDR.
// - W_MAX: one write of cfg_ctr_max to `CTR_MAX_ADDR.
// - LOAD_W: w_ready=1. Each w_valid&w_ready beat writes w_data to `WEIGHT_ADDR_BASE+w_idx in the next cycle.
//   The beat with w_last goes to W_START. LOAD_W with no beats stalls indefinitely; zero-weight jobs still send one beat.
// - W_START: writes 32'h1 to `START_ADDR. The counter loads cfg_anneal.
// - ANNEAL: counter decrements each cycle and exits on reaching 0. cfg_anneal=0 exits after one cycle.
// - RD_REQ: araddr_q = `PHASE_ADDR_BASE + 4*i, arvalid_q=1, i from 0 to N-1.
// - RD_WAIT: hold RD_LATENCY cycles, then shift register slot i <= rdata[0].
//   After slot i, i++ and return to RD_REQ; after i=N-1 go to FINISH. Each spin costs 1+RD_LATENCY cycles.
// - FINISH: phase_vec <= shift register; done=1 for one cycle; -> IDLE.
// - job_start while busy is ignored; no queueing.
// - job_abort, or axi_rst mid-job: -> IDLE next cycle; no START write is issued.
//   phase_vec keeps its old value (axi_rst clears it); done does not pulse.
//   An abort during ANNEAL leaves ising_axi running; the next job re-writes its config.
// - wr_en and arvalid_q are never high in the same cycle.
// - Write count per job: 3 + number of weight beats.
// TESTING
// - Reset mid-ANNEAL: assert axi_rst -> all outputs 0 asynchronously. Release -> IDLE; job_start works normally.
// - Max-cut job, N=8: cutoff=0x4000, max=0x8000, anneal=1000.
//   10 weights: AB,AE,BC,BD,CD,DE=1; AH,BH,CH,DH=4.
//   Bench has a scoreboard; result phase_vec bits {7,4,3,2,1,0}={1,0,1,1,0,1}.
// - Register write trace: exactly 13 writes. Order is CUTOFF, MAX, 10 weights, START, each with correct addr/data.
//   Weight stream with w_valid gaps of 0..5 cycles -> identical trace.
// - Readback timing with a model slave: rdata = 0xA5 pattern per address.
//   N requests at addresses BASE+0..BASE+28 spaced 1+RD_LATENCY; done exactly 1 cycle after the last capture.
// - job_abort in LOAD_W after 3 beats: no START write, busy=0 next cycle, no done.
//   A following full job completes correctly.
// - job_start pulsed in W_MAX and in ANNEAL -> ignored; write count is still 13.

Source files
------------

// File: rtl/ising_job_sequencer.sv
// ising_job_sequencer: programs one ising_axi instance per anneal job and
// collects the N spin phases into phase_vec when the anneal time has elapsed.
// Ports: clk, axi_rst (async, active high)
//   job_start/job_abort/cfg_*  : job control and per-job configuration
//   w_valid/w_ready/w_idx/w_data/w_last : weight stream (valid/ready)
//   wr_en/wr_addr/wdata        : single-cycle register writes to ising_axi
//   arvalid_q/araddr_q/rdata   : phase readback, rdata[0] = phase
//   busy/done/phase_vec        : status and result
module ising_job_sequencer #(
  parameter int unsigned N                = 8,
  parameter int unsigned WIDX_W           = 32,
  parameter int unsigned ANNEAL_W         = 32,
  parameter int unsigned RD_LATENCY       = 1,
  parameter logic [31:0] START_ADDR       = 32'h0000_0000,
  parameter logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0004,
  parameter logic [31:0] CTR_MAX_ADDR     = 32'h0000_0008,
  parameter logic [31:0] WEIGHT_ADDR_BASE = 32'h0000_1000,
  parameter logic [31:0] PHASE_ADDR_BASE  = 32'h0000_2000
) (
  input  logic                clk,
  input  logic                axi_rst,
  input  logic                job_start,
  input  logic                job_abort,
  input  logic [31:0]         cfg_cutoff,
  input  logic [31:0]         cfg_ctr_max,
  input  logic [ANNEAL_W-1:0] cfg_anneal,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [WIDX_W-1:0]   w_idx,
  input  logic [31:0]         w_data,
  input  logic                w_last,
  output logic                wr_en,
  output logic [31:0]         wr_addr,
  output logic [31:0]         wdata,
  output logic                arvalid_q,
  output logic [31:0]         araddr_q,
  input  logic [31:0]         rdata,
  output logic                busy,
  output logic                done,
  output logic [N-1:0]        phase_vec
);

  localparam int unsigned IDX_W =
    (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LAT_W =
    (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [3:0] {
    IDLE,
    W_CUT,
    W_MAX,
    LOAD_W,
    W_START,
    ANNEAL,
    RD_REQ,
    RD_WAIT,
    FINISH
  } state_e;

  state_e              state_q, state_d;
  logic                wr_en_q, wr_en_d;
  logic [31:0]         wr_addr_q, wr_addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                arvalid_d;
  logic [31:0]         araddr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                w_ready_q, w_ready_d;
  logic [N-1:0]        phase_q, phase_d;
  logic [N-1:0]        sh_q, sh_d;
  logic [31:0]         max_q, max_d;
  logic [ANNEAL_W-1:0] ann_q, ann_d;
  logic [ANNEAL_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LAT_W-1:0]    lat_q, lat_d;

  // Only the phase bit of each readback word matters.
  logic unused_rdata;
  assign unused_rdata = ^rdata[31:1];

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wdata_d   = wdata_q;
    arvalid_d = 1'b0;
    araddr_d  = araddr_q;
    done_d    = 1'b0;
    phase_d   = phase_q;
    sh_d      = sh_q;
    max_d     = max_q;
    ann_d     = ann_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    lat_d     = lat_q;

    unique case (state_q)
      IDLE: begin
        if (job_start) begin
          state_d   = W_CUT;
          max_d     = cfg_ctr_max;
          ann_d     = cfg_anneal;
          wr_en_d   = 1'b1;
          wr_addr_d = CTR_CUTOFF_ADDR;
          wdata_d   = cfg_cutoff;
        end
      end
      W_CUT: begin
        state_d   = W_MAX;
        wr_en_d   = 1'b1;
        wr_addr_d = CTR_MAX_ADDR;
        wdata_d   = max_q;
      end
      W_MAX: begin
        state_d = LOAD_W;
      end
      LOAD_W: begin
        if (w_valid && w_ready_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = WEIGHT_ADDR_BASE + 32'(w_idx);
          wdata_d   = w_data;
          if (w_last) state_d = W_START;
        end
      end
      W_START: begin
        state_d   = ANNEAL;
        wr_en_d   = 1'b1;
        wr_addr_d = START_ADDR;
        wdata_d   = 32'h1;
        cnt_d     = ann_q;
      end
      ANNEAL: begin
        if (cnt_q == '0) begin
          state_d   = RD_REQ;
          idx_d     = '0;
          arvalid_d = 1'b1;
          araddr_d  = PHASE_ADDR_BASE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_REQ: begin
        state_d = RD_WAIT;
        lat_d   = LAT_W'(RD_LATENCY - 1);
      end
      RD_WAIT: begin
        if (lat_q != '0) begin
          lat_d = lat_q - 1'b1;
        end else begin
          sh_d[idx_q] = rdata[0];
          if (idx_q == IDX_W'(N - 1)) begin
            // Publish together with done.
            state_d = FINISH;
            done_d  = 1'b1;
            phase_d = sh_d;
          end else begin
            state_d   = RD_REQ;
            idx_d     = idx_q + 1'b1;
            arvalid_d = 1'b1;
            araddr_d  = PHASE_ADDR_BASE
                      + (32'(idx_d) << 2);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort squashes anything not yet on the outputs,
    // including a pending START write.
    if (job_abort) begin
      state_d   = IDLE;
      wr_en_d   = 1'b0;
      arvalid_d = 1'b0;
      done_d    = 1'b0;
      phase_d   = phase_q;
    end

    busy_d    = (state_d != IDLE);
    w_ready_d = (state_d == LOAD_W);
  end

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_ready_q <= 1'b0;
      phase_q   <= '0;
      sh_q      <= '0;
      max_q     <= '0;
      ann_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wdata_q   <= wdata_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      w_ready_q <= w_ready_d;
      phase_q   <= phase_d;
      sh_q      <= sh_d;
      max_q     <= max_d;
      ann_q     <= ann_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      lat_q     <= lat_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wdata     = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign w_ready   = w_ready_q;
  assign phase_vec = phase_q;

endmodule

// File: tb/tb_ising_job_sequencer.sv
// tb_ising_job_sequencer: job-level checks of ising_job_sequencer against
// a write-trace / readback model and a model ising_axi read slave.
module tb_ising_job_sequencer;

  localparam int N = 8;
  localparam int L = 1;
  localparam logic [31:0] A_START = 32'h0000_0000;
  localparam logic [31:0] A_CUT   = 32'h0000_0004;
  localparam logic [31:0] A_MAX   = 32'h0000_0008;
  localparam logic [31:0] A_WB    = 32'h0000_1000;
  localparam logic [31:0] A_PB    = 32'h0000_2000;

  logic         clk = 1'b0;
  logic         axi_rst, job_start, job_abort;
  logic [31:0]  cfg_cutoff, cfg_ctr_max, cfg_anneal;
  logic         w_valid, w_ready, w_last;
  logic [31:0]  w_idx, w_data;
  logic         wr_en;
  logic [31:0]  wr_addr, wdata;
  logic         arvalid_q;
  logic [31:0]  araddr_q, rdata;
  logic         busy, done;
  logic [N-1:0] phase_vec;

  always #5 clk = ~clk;

  ising_job_sequencer #(
    .N(N), .WIDX_W(32), .ANNEAL_W(32), .RD_LATENCY(L),
    .START_ADDR(A_START), .CTR_CUTOFF_ADDR(A_CUT),
    .CTR_MAX_ADDR(A_MAX), .WEIGHT_ADDR_BASE(A_WB),
    .PHASE_ADDR_BASE(A_PB)
  ) dut (
    .clk(clk), .axi_rst(axi_rst),
    .job_start(job_start), .job_abort(job_abort),
    .cfg_cutoff(cfg_cutoff), .cfg_ctr_max(cfg_ctr_max),
    .cfg_anneal(cfg_anneal),
    .w_valid(w_valid), .w_ready(w_ready), .w_idx(w_idx),
    .w_data(w_data), .w_last(w_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wdata(wdata),
    .arvalid_q(arvalid_q), .araddr_q(araddr_q), .rdata(rdata),
    .busy(busy), .done(done), .phase_vec(phase_vec)
  );

  // Model read slave: one-cycle latency, phase = pattern bit of the
  // addressed spin, upper bits random.
  logic [N-1:0] slv_pat;
  always @(posedge clk) begin : slave
    logic [31:0] j;
    int k;
    j = $urandom();
    k = int'((araddr_q - A_PB) >> 2) % N;
    rdata <= {j[31:1], slv_pat[k]};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wq_a[$], wq_d[$], rq_a[$];
  int wq_c[$], rq_c[$], dn_c[$];
  int ovl = 0;
  always @(negedge clk) begin
    if (!axi_rst) begin
      if (wr_en) begin
        wq_a.push_back(wr_addr);
        wq_d.push_back(wdata);
        wq_c.push_back(cyc);
      end
      if (arvalid_q) begin
        rq_a.push_back(araddr_q);
        rq_c.push_back(cyc);
      end
      if (done) dn_c.push_back(cyc);
      if (wr_en && arvalid_q) ovl = ovl + 1;
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [31:0] jw_i[$], jw_d[$];

  task automatic fill_maxcut();
    int ei[10] = '{0, 0, 1, 1, 2, 3, 0, 1, 2, 3};
    int ej[10] = '{1, 4, 2, 3, 3, 4, 7, 7, 7, 7};
    jw_i.delete();
    jw_d.delete();
    for (int k = 0; k < 10; k++) begin
      jw_i.push_back(32'(4 * (ei[k] * N + ej[k])));
      jw_d.push_back((k < 6) ? 32'd1 : 32'd4);
    end
  endtask

  // mode 0: full job, 1: abort after nabort beats, 2: reset in ANNEAL
  task automatic run_job(input string tag,
                         input logic [31:0] cut,
                         input logic [31:0] mx,
                         input logic [31:0] an,
                         input int gapmax, input int mode,
                         input int nabort, input bit ign,
                         input logic [N-1:0] pat,
                         input logic [N-1:0] exp_ph,
                         input int exp_wr);
    int w0, r0, d0, tmo, nw, nst, sc;
    logic [N-1:0] old_ph;
    logic [31:0] ea[$], ed[$];
    logic [63:0] got;
    w0 = wq_a.size();
    r0 = rq_a.size();
    d0 = dn_c.size();
    nw = jw_i.size();
    slv_pat = pat;
    old_ph = phase_vec;
    @(negedge clk);
    cfg_cutoff = cut;
    cfg_ctr_max = mx;
    cfg_anneal = an;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    cfg_cutoff = $urandom();
    cfg_ctr_max = $urandom();
    cfg_anneal = $urandom_range(0, 5000);
    if (ign) begin
      @(negedge clk);
      job_start = 1'b1;
      @(negedge clk);
      job_start = 1'b0;
    end
    for (int k = 0; k < nw; k++) begin
      if (mode == 1 && k == nabort) break;
      w_valid = 1'b0;
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
      w_valid = 1'b1;
      w_idx = jw_i[k];
      w_data = jw_d[k];
      w_last = (k == nw - 1);
      tmo = 0;
      while (!w_ready && tmo < 50) begin
        @(negedge clk);
        tmo++;
      end
      chk($sformatf("%s w_ready beat%0d", tag, k), 64'(tmo < 50), 1);
      @(negedge clk);
    end
    w_valid = 1'b0;
    w_last = 1'b0;

    if (mode == 1) begin
      job_abort = 1'b1;
      @(negedge clk);
      job_abort = 1'b0;
      chk({tag, " busy after abort"}, busy, 0);
      repeat (20) @(negedge clk);
      nst = 0;
      for (int k = w0; k < wq_a.size(); k++)
        if (wq_a[k] == A_START) nst++;
      chk({tag, " writes"}, wq_a.size() - w0, exp_wr);
      chk({tag, " start writes"}, nst, 0);
      chk({tag, " reads"}, rq_a.size() - r0, 0);
      chk({tag, " done pulses"}, dn_c.size() - d0, 0);
      chk({tag, " phase kept"}, phase_vec, old_ph);
      return;
    end

    if (ign || mode == 2) begin
      tmo = 0;
      while (!(wr_en && wr_addr == A_START) && tmo < 50) begin
        @(negedge clk);
        tmo++;
      end
      chk({tag, " start seen"}, 64'(tmo < 50), 1);
      if (ign) begin
        job_start = 1'b1;
        @(negedge clk);
        job_start = 1'b0;
      end
    end

    if (mode == 2) begin
      repeat (20) @(negedge clk);
      #2 axi_rst = 1'b1;
      #1;
      chk({tag, " rst ctrl"},
          {busy, done, wr_en, arvalid_q, w_ready, phase_vec}, 0);
      chk({tag, " rst wr"}, {wr_addr, wdata}, 0);
      chk({tag, " rst araddr"}, araddr_q, 0);
      @(negedge clk);
      axi_rst = 1'b0;
      @(negedge clk);
      chk({tag, " idle after release"}, busy, 0);
      return;
    end

    tmo = 0;
    while (done !== 1'b1 && tmo < int'(an) + 300) begin
      @(negedge clk);
      tmo++;
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " phase_vec"}, phase_vec, exp_ph);
    @(negedge clk);
    chk({tag, " busy cleared"}, busy, 0);

    ea = '{A_CUT, A_MAX};
    ed = '{cut, mx};
    for (int k = 0; k < nw; k++) begin
      ea.push_back(A_WB + jw_i[k]);
      ed.push_back(jw_d[k]);
    end
    ea.push_back(A_START);
    ed.push_back(32'h1);
    chk({tag, " write count"}, wq_a.size() - w0, exp_wr);
    for (int k = 0; k < ea.size(); k++) begin
      got = (w0 + k < wq_a.size())
          ? {wq_a[w0 + k], wq_d[w0 + k]} : 64'hX;
      chk($sformatf("%s wr%0d", tag, k), got, {ea[k], ed[k]});
    end
    chk({tag, " read count"}, rq_a.size() - r0, N);
    if (rq_a.size() - r0 == N) begin
      sc = (wq_c.size() > w0) ? wq_c[wq_c.size() - 1] : 0;
      chk({tag, " anneal wait"}, rq_c[r0] - sc, int'(an) + 1);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("%s rd%0d addr", tag, i), rq_a[r0 + i],
            A_PB + 32'(4 * i));
        if (i > 0)
          chk($sformatf("%s rd%0d spacing", tag, i),
              rq_c[r0 + i] - rq_c[r0 + i - 1], 1 + L);
      end
      chk({tag, " done count"}, dn_c.size() - d0, 1);
      if (dn_c.size() - d0 == 1)
        chk({tag, " done timing"},
            dn_c[d0] - rq_c[r0 + N - 1], 1 + L);
    end
  endtask

  typedef struct {
    logic [31:0]  cut;
    logic [31:0]  mx;
    logic [31:0]  an;
    int           nw;
    int           gap;
    logic [N-1:0] pat;
    logic [N-1:0] exp_ph;
    int           exp_wr;
  } vec_t;

  vec_t tbl[4];
  logic [31:0] sv_a[$], sv_d[$];
  int w0;
  logic [N-1:0] rp;
  logic [31:0] rc, rm, ra;
  int rn;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h0000_0011, 32'h0000_0022, 32'd0, 1, 0,
               8'h00, 8'h00, 4};
    tbl[1] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'd2, 5, 2,
               8'hA5, 8'hA5, 8};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'd1, 3, 5,
               8'hFF, 8'hFF, 6};
    tbl[3] = '{32'h0000_4000, 32'h0000_8000, 32'd7, 8, 1,
               8'h5A, 8'h5A, 11};

    axi_rst = 1'b1;
    job_start = 1'b0;
    job_abort = 1'b0;
    cfg_cutoff = '0;
    cfg_ctr_max = '0;
    cfg_anneal = '0;
    w_valid = 1'b0;
    w_idx = '0;
    w_data = '0;
    w_last = 1'b0;
    slv_pat = '0;
    repeat (3) @(negedge clk);
    chk("reset ctrl",
        {busy, done, wr_en, arvalid_q, w_ready, phase_vec}, 0);
    chk("reset wr", {wr_addr, wdata}, 0);
    chk("reset araddr", araddr_q, 0);
    axi_rst = 1'b0;
    @(negedge clk);
    chk("idle after release", busy, 0);

    for (int i = 0; i < 4; i++) begin
      jw_i.delete();
      jw_d.delete();
      for (int k = 0; k < tbl[i].nw; k++) begin
        jw_i.push_back(32'(4 * ((k * 7 + i) % 64)));
        jw_d.push_back(32'hC0DE_0000 + 32'(16 * i + k));
      end
      run_job($sformatf("vec%0d", i), tbl[i].cut, tbl[i].mx,
              tbl[i].an, tbl[i].gap, 0, 0, 1'b0, tbl[i].pat,
              tbl[i].exp_ph, tbl[i].exp_wr);
    end

    fill_maxcut();
    w0 = wq_a.size();
    run_job("maxcut", 32'h4000, 32'h8000, 32'd1000, 0, 0, 0,
            1'b0, 8'h8D, 8'h8D, 13);
    chk("maxcut spins", {phase_vec[7], phase_vec[4:0]}, 6'b101101);
    for (int k = w0; k < wq_a.size(); k++) begin
      sv_a.push_back(wq_a[k]);
      sv_d.push_back(wq_d[k]);
    end
    w0 = wq_a.size();
    run_job("maxcut_gaps", 32'h4000, 32'h8000, 32'd1000, 5, 0, 0,
            1'b1, 8'h8D, 8'h8D, 13);
    chk("gap trace len", wq_a.size() - w0, sv_a.size());
    for (int k = 0; k < sv_a.size(); k++)
      if (w0 + k < wq_a.size())
        chk($sformatf("gap trace %0d", k),
            {wq_a[w0 + k], wq_d[w0 + k]}, {sv_a[k], sv_d[k]});

    run_job("abort", 32'h4000, 32'h8000, 32'd1000, 2, 1, 3,
            1'b0, 8'h33, 8'h33, 5);
    run_job("post_abort", 32'h4000, 32'h8000, 32'd10, 2, 0, 0,
            1'b0, 8'hA5, 8'hA5, 13);

    run_job("rst_anneal", 32'h4000, 32'h8000, 32'd1000, 1, 2, 0,
            1'b0, 8'h8D, 8'h8D, 13);
    run_job("post_reset", 32'h4000, 32'h8000, 32'd1000, 0, 0, 0,
            1'b0, 8'h8D, 8'h8D, 13);
    chk("post_reset spins", {phase_vec[7], phase_vec[4:0]},
        6'b101101);

    for (int r = 0; r < 6; r++) begin
      rn = $urandom_range(1, 6);
      jw_i.delete();
      jw_d.delete();
      for (int k = 0; k < rn; k++) begin
        jw_i.push_back(32'(4 * $urandom_range(0, 63)));
        jw_d.push_back($urandom());
      end
      rc = $urandom();
      rm = $urandom();
      ra = $urandom_range(0, 20);
      rp = N'($urandom());
      run_job($sformatf("rnd%0d", r), rc, rm, ra, 3, 0, 0,
              1'b0, rp, rp, 3 + rn);
    end

    chk("wr/rd overlap cycles", ovl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
